// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver (16x oversampling) feeding a small byte FIFO
//            with head-of-queue read port, sticky error flags and level IRQ.
//            Define UART_RX_PARITY_EN to add an even-parity bit to the frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [7:0]               rdata,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     irq
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rxs_q;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      scnt_q, scnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovr_q, fe_q;
    logic            tick, push_req, fe_set;
    logic            full, empty, do_push, do_pop, ovr_set;

    assign tick = (state_q != IDLE) && (div_q == DW'(DIV - 1));

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d, pe_q, pe_set;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
        scnt_d   = tick ? scnt_q + 4'd1 : scnt_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        push_req = 1'b0;
        fe_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
        pe_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                scnt_d = 4'd0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick && scnt_q == 4'd7) begin
                    scnt_d  = 4'd0;
                    bidx_d  = 3'd0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && scnt_q == 4'd15) begin
                    shreg_d[bidx_q] = rxs_q;
                    if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && scnt_q == 4'd15) begin
                    perr_d  = ^shreg_q ^ rxs_q;
                    pe_set  = perr_d;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick && scnt_q == 4'd15) begin
                    state_d = IDLE;
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        push_req = !perr_q;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        fe_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovr_set = push_req && full && !pop;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            scnt_q  <= 4'd0;
            bidx_q  <= 3'd0;
            shreg_q <= 8'h00;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            ovr_q   <= (ovr_q & ~clr_err) | ovr_set;
            fe_q    <= (fe_q & ~clr_err) | fe_set;
            if (do_push) begin
                mem_q[wptr_q] <= shreg_q;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + AW'(1);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            perr_q <= perr_d;
            pe_q   <= (pe_q & ~clr_err) | pe_set;
        end
    end
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rdata     = empty ? 8'h00 : mem_q[rptr_q];
    assign rx_valid  = !empty;
    assign irq       = !empty;
    assign count     = count_q;
    assign overrun   = ovr_q;
    assign frame_err = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Randomized scoreboard bench for uart_rx_fifo (16 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 1000000;
    localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FBITS  = 11;
`else
    localparam int FBITS  = 10;
`endif
    // Negedges from the start-bit edge until the byte is visible.
    localparam int VIS = 11 + 16 * (FBITS - 1);

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       rx     = 1'b1;
    logic       pop_mon = 1'b0, pop_main = 1'b0;
    logic       pop;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       rx_valid, overrun, frame_err, parity_err, irq;
    logic [$clog2(DEPTH):0] count;

    assign pop = pop_mon | pop_main;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .sysclk(sysclk), .reset(reset), .rx(rx), .pop(pop), .clr_err(clr_err),
        .rdata(rdata), .rx_valid(rx_valid), .count(count), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         level = 0;
    logic       exp_ovr = 0, exp_fe = 0, exp_pe = 0;
    logic       drain_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model decides the fate of the frame when it is issued.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        if (stop && par_ok) begin
            if (level < DEPTH) begin
                exp_q.push_back(b);
                level++;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        if (!stop) exp_fe = 1'b1;
        if (!par_ok) exp_pe = 1'b1;
        @(negedge sysclk);
        rx = 1'b0;
        repeat (16) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge sysclk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? ^b : ~^b;
        repeat (16) @(negedge sysclk);
`endif
        rx = stop;
        repeat (16) @(negedge sysclk);
        rx = 1'b1;
        if (!stop) repeat (16) @(negedge sysclk);
    endtask

    task automatic do_clr();
        @(negedge sysclk);
        clr_err = 1'b1;
        @(negedge sysclk);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        exp_pe  = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, " overrun"}, overrun, exp_ovr);
        chk({tag, " frame_err"}, frame_err, exp_fe);
        chk({tag, " parity_err"}, parity_err, exp_pe);
        chk({tag, " count"}, count, level);
    endtask

    task automatic wait_drained(input string tag);
        int t = 0;
        drain_en = 1'b1;
        while ((exp_q.size() != 0 || rx_valid) && t < 3000) begin
            @(negedge sysclk);
            t++;
        end
        @(negedge sysclk);
        drain_en = 1'b0;
        chk({tag, " drain timeout"}, (t < 3000), 1);
        chk({tag, " empty rx_valid"}, rx_valid, 0);
        chk({tag, " empty rdata"}, rdata, 0);
        chk({tag, " empty irq"}, irq, 0);
        chk({tag, " empty count"}, count, 0);
    endtask

    // Monitor: consumes bytes whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge sysclk);
            if (drain_en && rx_valid) begin
                repeat ($urandom_range(0, 6)) @(negedge sysclk);
                chk("irq follows rx_valid", irq, rx_valid);
                if (exp_q.size() == 0) begin
                    chk("unexpected byte", rdata, 32'hFFFF_FFFF);
                end else begin
                    chk("rdata", rdata, exp_q.pop_front());
                end
                pop_mon = 1'b1;
                @(negedge sysclk);
                pop_mon = 1'b0;
                level--;
            end else if (drain_en && !rx_valid && $urandom_range(0, 15) == 0) begin
                pop_mon = 1'b1;
                @(negedge sysclk);
                pop_mon = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        repeat (3) @(negedge sysclk);
        chk("reset rdata", rdata, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset irq", irq, 0);
        check_flags("reset");
        reset = 1'b1;
        repeat (5) @(negedge sysclk);

        // Single byte with exact visibility latency
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge sysclk);
                repeat (VIS - 1) @(negedge sysclk);
                chk("t1 valid before sample", rx_valid, 0);
                @(negedge sysclk);
                chk("t1 valid after sample", rx_valid, 1);
                chk("t1 irq", irq, 1);
                chk("t1 rdata", rdata, 8'hA5);
                chk("t1 count", count, 1);
            end
        join
        wait_drained("t1");

        // Start-bit glitch
        @(negedge sysclk);
        rx = 1'b0;
        repeat (4) @(negedge sysclk);
        rx = 1'b1;
        repeat (40) @(negedge sysclk);
        check_flags("t2");

        // Overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        check_flags("t3 full");
        wait_drained("t3");
        chk("t3 overrun sticky", overrun, 1);
        do_clr();
        check_flags("t3 clr");

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) send_frame(8'h61 + 8'(i), 1'b1, 1'b1);
        e = exp_q.pop_front();
        level--;
        fork
            send_frame(8'h65, 1'b1, 1'b1);
            begin
                @(negedge sysclk);
                repeat (VIS - 1) @(negedge sysclk);
                chk("full pop rdata", rdata, e);
                pop_main = 1'b1;
                @(negedge sysclk);
                pop_main = 1'b0;
            end
        join
        check_flags("full push+pop");
        wait_drained("full push+pop");

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b1);
        check_flags("t4 bad stop");
        send_frame(8'h3C, 1'b1, 1'b1);
        chk("t4 rdata", rdata, 8'h3C);
        wait_drained("t4");
        do_clr();
        check_flags("t4 clr");

        // Reset mid-frame with state present
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        check_flags("t5 pre");
        @(negedge sysclk);
        rx = 1'b0;
        repeat (16) @(negedge sysclk);
        rx = 1'b1;
        repeat (56) @(negedge sysclk);
        reset = 1'b0;
        #1;
        exp_q.delete();
        level = 0;
        exp_ovr = 0;
        exp_fe = 0;
        exp_pe = 0;
        chk("t5 rst rdata", rdata, 0);
        chk("t5 rst rx_valid", rx_valid, 0);
        chk("t5 rst irq", irq, 0);
        check_flags("t5 rst");
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        repeat (100) @(negedge sysclk);
        check_flags("t5 after abandoned frame");
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("t5 rdata", rdata, 8'h5A);
        check_flags("t5 post");
        wait_drained("t5");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check_flags("t6 bad parity");
        send_frame(8'h07, 1'b1, 1'b1);
        chk("t6 rdata", rdata, 8'h07);
        wait_drained("t6");
        do_clr();
`else
        send_frame(8'h07, 1'b1, 1'b1);
        chk("t6 rdata", rdata, 8'h07);
        check_flags("t6");
        wait_drained("t6");
`endif

        // Randomized traffic with concurrent draining
        drain_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1'b1);
            repeat ($urandom_range(0, 12)) @(negedge sysclk);
        end
        wait_drained("random");
        check_flags("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
